// File: rtl/mips_regfile_param.sv
// MIPS general-purpose register file: two combinational read ports and one clocked write port.
// After reset an init sweep loads INIT_VALUE into every entry; reg_ready gates the datapath until then.
module mips_regfile_param #(
  parameter int unsigned          DATA_W     = 32,
  parameter int unsigned          ADDR_W     = 5,
  parameter int unsigned          DEPTH      = 32,
  parameter bit                   ZERO_REG   = 1'b1,
  parameter bit                   BYPASS     = 1'b1,
  parameter logic [DATA_W-1:0]    INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              signal_reg_write,
  output logic              reg_ready,
  output logic              write_err
);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  localparam logic [ADDR_W:0] DEPTH_W   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] INIT_LAST = (ADDR_W+1)'(DEPTH - 1);

  state_t              state, state_nxt;
  logic [ADDR_W:0]     init_cnt, init_cnt_nxt;
  logic                ready_nxt;
  logic                err_nxt;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                wr_accept;
  logic [DATA_W-1:0]   mem [0:DEPTH-1];

  function automatic logic is_mapped(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DEPTH_W);
  endfunction

  function automatic logic is_hard_zero(input logic [ADDR_W-1:0] addr);
    return ZERO_REG && (addr == '0);
  endfunction

  // Read mux shared by both ports; forwarding only ever reflects a write that will land.
  function automatic logic [DATA_W-1:0] read_sel(
    input logic [ADDR_W-1:0] raddr,
    input logic [DATA_W-1:0] stored,
    input logic              ready,
    input logic              accept,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    if (!ready || !is_mapped(raddr) || is_hard_zero(raddr))
      return '0;
    if (BYPASS && accept && (waddr == raddr))
      return wdata;
    return stored;
  endfunction

  assign wr_accept = !rst && (state == RUN) && signal_reg_write &&
                     is_mapped(write_reg) && !is_hard_zero(write_reg);

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    ready_nxt    = reg_ready;
    err_nxt      = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = write_reg;
    mem_wdata    = write_data;
    case (state)
      INIT: begin
        mem_we       = 1'b1;
        mem_waddr    = init_cnt[ADDR_W-1:0];
        mem_wdata    = INIT_VALUE;
        init_cnt_nxt = init_cnt + 1'b1;
        err_nxt      = signal_reg_write;
        if (init_cnt == INIT_LAST) begin
          state_nxt = RUN;
          ready_nxt = 1'b1;
        end
      end
      RUN: begin
        mem_we  = wr_accept;
        err_nxt = signal_reg_write && !is_mapped(write_reg);
      end
      default: state_nxt = INIT;
    endcase
    if (rst) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      init_cnt  <= '0;
      reg_ready <= 1'b0;
      write_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_cnt  <= init_cnt_nxt;
      reg_ready <= ready_nxt;
      write_err <= err_nxt;
    end
  end

  // Storage has no reset; the init sweep is what clears it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign read_data_1 = read_sel(read_reg_1, mem[read_reg_1], reg_ready, wr_accept,
                                write_reg, write_data);
  assign read_data_2 = read_sel(read_reg_2, mem[read_reg_2], reg_ready, wr_accept,
                                write_reg, write_data);

endmodule

// File: tb/tb_mips_regfile_param.sv
// Directed bench: one default instance (bypass, zero reg, 32 entries) and one variant
// (no bypass, ordinary r0, 24 entries, non-zero init value) driven from shared inputs.
module tb_mips_regfile_param;

  localparam logic [31:0] INIT_B = 32'h0000_1111;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rr1, rr2, wr;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        ready_a, err_a, ready_b, err_b;

  int total = 0;
  int bad   = 0;
  logic [31:0] ma [0:31];
  logic [31:0] mb [0:31];

  always #5 clk = ~clk;

  mips_regfile_param dut_a (
    .clk(clk), .rst(rst),
    .read_reg_1(rr1), .read_reg_2(rr2),
    .read_data_1(rd1_a), .read_data_2(rd2_a),
    .write_reg(wr), .write_data(wd), .signal_reg_write(we),
    .reg_ready(ready_a), .write_err(err_a)
  );

  mips_regfile_param #(
    .DATA_W(32), .ADDR_W(5), .DEPTH(24), .ZERO_REG(1'b0), .BYPASS(1'b0), .INIT_VALUE(INIT_B)
  ) dut_b (
    .clk(clk), .rst(rst),
    .read_reg_1(rr1), .read_reg_2(rr2),
    .read_data_1(rd1_b), .read_data_2(rd2_b),
    .write_reg(wr), .write_data(wd), .signal_reg_write(we),
    .reg_ready(ready_b), .write_err(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_models();
    for (int i = 0; i < 32; i++) begin
      ma[i] = 32'h0;
      mb[i] = (i < 24) ? INIT_B : 32'h0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int a = 0; a < 32; a++) begin
      rr1 = 5'(a);
      rr2 = 5'(31 - a);
      #1;
      chk($sformatf("%s rd1_a[%0d]", tag, a), rd1_a, ma[a]);
      chk($sformatf("%s rd2_a[%0d]", tag, 31 - a), rd2_a, ma[31 - a]);
      chk($sformatf("%s rd1_b[%0d]", tag, a), rd1_b, mb[a]);
      chk($sformatf("%s rd2_b[%0d]", tag, 31 - a), rd2_b, mb[31 - a]);
    end
  endtask

  task automatic init_sweep(input string tag, input bit poke_r3);
    for (int i = 1; i <= 32; i++) begin
      if (poke_r3 && i == 5) begin
        we = 1'b1; wr = 5'd3; wd = 32'h55;
      end else begin
        we = 1'b0;
      end
      tick();
      chk($sformatf("%s ready_a@%0d", tag, i), {31'b0, ready_a}, {31'b0, i >= 32});
      chk($sformatf("%s ready_b@%0d", tag, i), {31'b0, ready_b}, {31'b0, i >= 24});
      if (i < 24) chk($sformatf("%s forced0_b@%0d", tag, i), rd1_b, 32'h0);
      if (poke_r3 && i == 5) begin
        chk("init_wr err_a", {31'b0, err_a}, 32'h1);
        chk("init_wr err_b", {31'b0, err_b}, 32'h1);
      end
      if (poke_r3 && i == 6) begin
        chk("init_wr err_a clear", {31'b0, err_a}, 32'h0);
        chk("init_wr err_b clear", {31'b0, err_b}, 32'h0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; rr1 = 5'd3; rr2 = 5'd7; wr = '0; wd = '0;
    reset_models();

    tick(); tick();
    chk("rst ready_a", {31'b0, ready_a}, 32'h0);
    chk("rst ready_b", {31'b0, ready_b}, 32'h0);
    chk("rst err_a",   {31'b0, err_a},   32'h0);
    chk("rst err_b",   {31'b0, err_b},   32'h0);
    rst = 1'b0;

    // Sweep with a write attempted at init cycle 4; r3 must still hold the init value.
    init_sweep("init", 1'b1);
    check_all("post_init");

    // Write r5: bypass instance shows it at once, the other only after the edge.
    rr1 = 5'd5; rr2 = 5'd5; wr = 5'd5; wd = 32'hDEAD_BEEF; we = 1'b1;
    #1;
    chk("byp rd1_a", rd1_a, 32'hDEAD_BEEF);
    chk("byp rd2_a", rd2_a, 32'hDEAD_BEEF);
    chk("nobyp rd1_b", rd1_b, INIT_B);
    tick();
    we = 1'b0;
    #1;
    chk("wr5 err_a", {31'b0, err_a}, 32'h0);
    chk("wr5 err_b", {31'b0, err_b}, 32'h0);
    chk("wr5 rd1_a", rd1_a, 32'hDEAD_BEEF);
    chk("wr5 rd1_b", rd1_b, 32'hDEAD_BEEF);
    ma[5] = 32'hDEAD_BEEF;
    mb[5] = 32'hDEAD_BEEF;

    // Write r0: hardwired zero discards silently and must not be forwarded.
    rr1 = 5'd0; rr2 = 5'd0; wr = 5'd0; wd = 32'hFFFF_FFFF; we = 1'b1;
    #1;
    chk("r0 byp rd1_a", rd1_a, 32'h0);
    chk("r0 byp rd2_a", rd2_a, 32'h0);
    chk("r0 old rd1_b", rd1_b, INIT_B);
    tick();
    we = 1'b0;
    #1;
    chk("r0 err_a", {31'b0, err_a}, 32'h0);
    chk("r0 err_b", {31'b0, err_b}, 32'h0);
    chk("r0 rd1_a", rd1_a, 32'h0);
    chk("r0 rd2_b", rd2_b, 32'hFFFF_FFFF);
    mb[0] = 32'hFFFF_FFFF;

    // Write r30: mapped in the 32-entry file, unmapped in the 24-entry one.
    rr1 = 5'd30; rr2 = 5'd5; wr = 5'd30; wd = 32'h0000_1234; we = 1'b1;
    #1;
    chk("r30 byp rd1_a", rd1_a, 32'h0000_1234);
    chk("r30 rd2_a indep", rd2_a, 32'hDEAD_BEEF);
    chk("r30 nobyp rd1_b", rd1_b, 32'h0);
    tick();
    we = 1'b0;
    chk("r30 err_a", {31'b0, err_a}, 32'h0);
    chk("r30 err_b pulse", {31'b0, err_b}, 32'h1);
    tick();
    chk("r30 err_b clear", {31'b0, err_b}, 32'h0);
    ma[30] = 32'h0000_1234;
    check_all("post_unmapped");

    // Fill r1..r31 with their index, then reset from RUN.
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wr = 5'(i); wd = 32'(i);
      tick();
      chk($sformatf("fill err_b@%0d", i), {31'b0, err_b}, {31'b0, i >= 24});
      ma[i] = 32'(i);
      if (i < 24) mb[i] = 32'(i);
    end
    we = 1'b0;
    check_all("filled");

    rst = 1'b1;
    tick();
    chk("run_rst ready_a", {31'b0, ready_a}, 32'h0);
    chk("run_rst ready_b", {31'b0, ready_b}, 32'h0);
    chk("run_rst err_b",   {31'b0, err_b},   32'h0);
    rst = 1'b0;
    rr1 = 5'd3;
    init_sweep("resweep", 1'b0);
    reset_models();
    check_all("post_resweep");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
